// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU sharing block:
// widths, ALU control codes, requester ids and the response-slot states.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;
    localparam int ID_W   = 1;

    typedef logic [ID_W-1:0] id_t;

    localparam id_t ID_REQ0 = 1'b0;
    localparam id_t ID_REQ1 = 1'b1;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle of the shared ALU: two requester handshakes and one
// response handshake. Signal suffixes are from the arbiter's point of view.
interface alu_share_arbiter_if;
    import alu_pkg::*;

    logic              req0_valid_i;
    logic [DATA_W-1:0] req0_src1_i;
    logic [DATA_W-1:0] req0_src2_i;
    logic [CTRL_W-1:0] req0_ctrl_i;
    logic              req0_ready_o;

    logic              req1_valid_i;
    logic [DATA_W-1:0] req1_src1_i;
    logic [DATA_W-1:0] req1_src2_i;
    logic [CTRL_W-1:0] req1_ctrl_i;
    logic              req1_ready_o;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    id_t               rsp_id_o;
    logic [DATA_W-1:0] rsp_result_o;
    logic              rsp_zero_o;

    modport slave (
        input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
        output req0_ready_o,
        input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
        output req1_ready_o,
        input  rsp_ready_i,
        output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o
    );

    modport master (
        output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
        input  req0_ready_o,
        output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
        input  req1_ready_o,
        output rsp_ready_i,
        input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o
    );

endinterface

// File: rtl/alu.sv
// Existing 32-bit combinational ALU (AND/OR/ADD/SUB/SLT/NOR) with zero flag.
// Output is held at zero while reset is asserted.
module alu
    import alu_pkg::*;
(
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    logic signed [DATA_W-1:0] src1_s;
    logic signed [DATA_W-1:0] src2_s;

    assign src1_s = src1_i;
    assign src2_s = src2_i;

    always_comb begin
        result_o = '0;
        if (rst_i) begin
            case (ctrl_i)
                ALU_AND: result_o = src1_i & src2_i;
                ALU_OR:  result_o = src1_i | src2_i;
                ALU_ADD: result_o = src1_i + src2_i;
                ALU_SUB: result_o = src1_i - src2_i;
                // SLT is a signed comparison
                ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, (src1_s < src2_s)};
                ALU_NOR: result_o = ~(src1_i | src2_i);
                default: result_o = '0;
            endcase
        end
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant gated by en_i, with the
// last-granted id remembered only when adv_i reports an acceptance.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic       gnt_vld_o,
    output id_t        gnt_id_o
);

    id_t last_q;
    id_t last_d;

    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_id_o  = ID_REQ0;
        if (en_i) begin
            case (req_i)
                2'b01: begin
                    gnt_vld_o = 1'b1;
                    gnt_id_o  = ID_REQ0;
                end
                2'b10: begin
                    gnt_vld_o = 1'b1;
                    gnt_id_o  = ID_REQ1;
                end
                2'b11: begin
                    gnt_vld_o = 1'b1;
                    gnt_id_o  = id_t'(~last_q);
                end
                default: begin
                    gnt_vld_o = 1'b0;
                    gnt_id_o  = ID_REQ0;
                end
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (adv_i) begin
            last_d = gnt_id_o;
        end
    end

    // Resetting to REQ1 hands the first tie to requester 0.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_q <= ID_REQ1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, operand mux, and a
// single registered response slot tagged with the owning requester id.
module alu_share_arbiter
    import alu_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    alu_share_arbiter_if.slave   bus
);

    slot_state_e       state_q,  state_d;
    id_t               rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q,   zero_d;

    logic              slot_free;
    logic              arb_en;
    logic              gnt_vld;
    id_t               gnt_id;
    logic              ready0;
    logic              ready1;
    logic              accept;

    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    // The slot can take a new result if it is empty or being drained now.
    assign slot_free = (state_q == SLOT_EMPTY) || bus.rsp_ready_i;
    assign arb_en    = rst_i && slot_free;

    rr_arb2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (arb_en),
        .req_i     ({bus.req1_valid_i, bus.req0_valid_i}),
        .adv_i     (accept),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    assign ready0 = gnt_vld && (gnt_id == ID_REQ0);
    assign ready1 = gnt_vld && (gnt_id == ID_REQ1);
    assign accept = (bus.req0_valid_i && ready0) || (bus.req1_valid_i && ready1);

    assign bus.req0_ready_o = ready0;
    assign bus.req1_ready_o = ready1;

    always_comb begin
        alu_ctrl = bus.req0_ctrl_i;
        alu_src1 = bus.req0_src1_i;
        alu_src2 = bus.req0_src2_i;
        if (ready1) begin
            alu_ctrl = bus.req1_ctrl_i;
            alu_src1 = bus.req1_src1_i;
            alu_src2 = bus.req1_src2_i;
        end
    end

    alu u_alu (
        .rst_i    (rst_i),
        .ctrl_i   (alu_ctrl),
        .src1_i   (alu_src1),
        .src2_i   (alu_src2),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_comb begin
        state_d  = state_q;
        rsp_id_d = rsp_id_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (accept) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (!accept && bus.rsp_ready_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        // Payload changes only on acceptance; a bare drain leaves it in place.
        if (accept) begin
            rsp_id_d = gnt_id;
            result_d = alu_result;
            zero_d   = alu_zero;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= SLOT_EMPTY;
            rsp_id_q <= ID_REQ0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rsp_id_q <= rsp_id_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.rsp_valid_o  = (state_q == SLOT_FULL);
    assign bus.rsp_id_o     = rsp_id_q;
    assign bus.rsp_result_o = result_q;
    assign bus.rsp_zero_o   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: hand-computed ALU results, grant order,
// backpressure and reset behaviour.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter_if bus ();

    alu_share_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid_i = v;
        bus.req0_ctrl_i  = c;
        bus.req0_src1_i  = a;
        bus.req0_src2_i  = b;
    endtask

    task automatic set1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid_i = v;
        bus.req1_ctrl_i  = c;
        bus.req1_src1_i  = a;
        bus.req1_src2_i  = b;
    endtask

    initial begin
        // Reset with both requesters asserting valid: readys must stay low.
        set0(1'b1, ALU_ADD, 32'd5, 32'd3);
        set1(1'b1, ALU_OR, 32'd1, 32'd2);
        bus.rsp_ready_i = 1'b1;
        tick();
        tick();
        chk("rst_valid",  bus.rsp_valid_o,  32'd0);
        chk("rst_id",     bus.rsp_id_o,     32'd0);
        chk("rst_result", bus.rsp_result_o, 32'd0);
        chk("rst_zero",   bus.rsp_zero_o,   32'd0);
        chk("rst_rdy0",   bus.req0_ready_o, 32'd0);
        chk("rst_rdy1",   bus.req1_ready_o, 32'd0);

        // Test 1: single ADD from req0.
        rst = 1'b1;
        set1(1'b0, ALU_AND, 32'd0, 32'd0);
        #1;
        chk("t1_rdy0", bus.req0_ready_o, 32'd1);
        chk("t1_rdy1", bus.req1_ready_o, 32'd0);
        tick();
        set0(1'b0, ALU_AND, 32'd0, 32'd0);
        #1;
        chk("t1_valid",  bus.rsp_valid_o,  32'd1);
        chk("t1_id",     bus.rsp_id_o,     32'd0);
        chk("t1_result", bus.rsp_result_o, 32'd8);
        chk("t1_zero",   bus.rsp_zero_o,   32'd0);
        tick();
        chk("t1_drain_valid", bus.rsp_valid_o,  32'd0);
        chk("t1_drain_hold",  bus.rsp_result_o, 32'd8);

        // Test 2: tie straight after reset goes to req0 first.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set0(1'b1, ALU_SUB, 32'd7, 32'd7);
        set1(1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        #1;
        chk("t2_rdy0", bus.req0_ready_o, 32'd1);
        chk("t2_rdy1", bus.req1_ready_o, 32'd0);
        tick();
        set0(1'b0, ALU_AND, 32'd0, 32'd0);
        #1;
        chk("t2_id0",   bus.rsp_id_o,     32'd0);
        chk("t2_res0",  bus.rsp_result_o, 32'd0);
        chk("t2_zero0", bus.rsp_zero_o,   32'd1);
        chk("t2_rdy1b", bus.req1_ready_o, 32'd1);
        tick();
        set1(1'b0, ALU_AND, 32'd0, 32'd0);
        #1;
        chk("t2_id1",   bus.rsp_id_o,     32'd1);
        chk("t2_res1",  bus.rsp_result_o, 32'h0000_00FF);
        chk("t2_zero1", bus.rsp_zero_o,   32'd0);

        // Test 3: continuous contention alternates with no bubbles.
        set0(1'b1, ALU_ADD, 32'd1, 32'd1);
        set1(1'b1, ALU_ADD, 32'd2, 32'd2);
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t3_valid%0d", i), bus.rsp_valid_o, 32'd1);
            chk($sformatf("t3_id%0d", i), bus.rsp_id_o, 32'(i % 2));
            chk($sformatf("t3_res%0d", i), bus.rsp_result_o, (i % 2 == 1) ? 32'd4 : 32'd2);
            tick();
        end
        set0(1'b0, ALU_AND, 32'd0, 32'd0);
        set1(1'b0, ALU_AND, 32'd0, 32'd0);
        tick();

        // Test 4: backpressure holds the slot and blocks both requesters.
        set0(1'b1, ALU_AND, 32'h0000_00FF, 32'h0000_000F);
        bus.rsp_ready_i = 1'b0;
        #1;
        chk("t4_rdy0_empty", bus.req0_ready_o, 32'd1);
        tick();
        set0(1'b0, ALU_AND, 32'd0, 32'd0);
        set1(1'b1, ALU_NOR, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_valid%0d", i), bus.rsp_valid_o,  32'd1);
            chk($sformatf("t4_res%0d", i),   bus.rsp_result_o, 32'h0000_000F);
            chk($sformatf("t4_id%0d", i),    bus.rsp_id_o,     32'd0);
            chk($sformatf("t4_rdy0_%0d", i), bus.req0_ready_o, 32'd0);
            chk($sformatf("t4_rdy1_%0d", i), bus.req1_ready_o, 32'd0);
            tick();
        end
        bus.rsp_ready_i = 1'b1;
        #1;
        chk("t4_rdy1_release", bus.req1_ready_o, 32'd1);
        tick();
        set1(1'b0, ALU_AND, 32'd0, 32'd0);
        #1;
        chk("t4_id_after",   bus.rsp_id_o,     32'd1);
        chk("t4_res_after",  bus.rsp_result_o, 32'hFFFF_FFFF);
        chk("t4_zero_after", bus.rsp_zero_o,   32'd0);

        // Test 5: signed SLT, then AND producing zero.
        set1(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        tick();
        #1;
        chk("t5_slt_res",  bus.rsp_result_o, 32'd1);
        chk("t5_slt_zero", bus.rsp_zero_o,   32'd0);
        chk("t5_slt_id",   bus.rsp_id_o,     32'd1);
        set1(1'b1, ALU_AND, 32'h0000_000A, 32'h0000_0005);
        tick();
        set1(1'b0, ALU_AND, 32'd0, 32'd0);
        #1;
        chk("t5_and_res",  bus.rsp_result_o, 32'd0);
        chk("t5_and_zero", bus.rsp_zero_o,   32'd1);

        // Test 6: one-cycle reset with a full slot; last grant returns to favour req0.
        set0(1'b1, ALU_ADD, 32'd0, 32'd0);
        tick();
        set0(1'b0, ALU_AND, 32'd0, 32'd0);
        chk("t6_pre_valid", bus.rsp_valid_o, 32'd1);
        rst = 1'b0;
        set0(1'b1, ALU_ADD, 32'd4, 32'd4);
        set1(1'b1, ALU_ADD, 32'd6, 32'd6);
        #1;
        chk("t6_rst_rdy0", bus.req0_ready_o, 32'd0);
        chk("t6_rst_rdy1", bus.req1_ready_o, 32'd0);
        tick();
        #1;
        chk("t6_valid",  bus.rsp_valid_o,  32'd0);
        chk("t6_id",     bus.rsp_id_o,     32'd0);
        chk("t6_result", bus.rsp_result_o, 32'd0);
        chk("t6_zero",   bus.rsp_zero_o,   32'd0);
        rst = 1'b1;
        #1;
        chk("t6_tie_rdy0", bus.req0_ready_o, 32'd1);
        chk("t6_tie_rdy1", bus.req1_ready_o, 32'd0);
        tick();
        set0(1'b0, ALU_AND, 32'd0, 32'd0);
        set1(1'b0, ALU_AND, 32'd0, 32'd0);
        #1;
        chk("t6_tie_id",  bus.rsp_id_o,     32'd0);
        chk("t6_tie_res", bus.rsp_result_o, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
